// File: rtl/ahb3lite_interconnect_master_port.sv
// Per-master front end of the AHB3-Lite multi-layer switch: decode, grant hold, response mux, can_switch.
// Optional: define AHB3LITE_INTERCONNECT_SEQ2NONSEQ_EN to promote the first SEQ to a newly granted slave to NONSEQ.
module ahb3lite_interconnect_master_port #(
   parameter int unsigned HADDR_SIZE = 32,
   parameter int unsigned HDATA_SIZE = 32,
   parameter int unsigned SLAVES     = 8,
   parameter logic [SLAVES-1:0][HADDR_SIZE-1:0] SLAVE_ADDR = '0,
   parameter logic [SLAVES-1:0][HADDR_SIZE-1:0] SLAVE_MASK = '0
) (
   input  logic                              HCLK,
   input  logic                              HRESET,
   input  logic                              HSEL,
   input  logic [HADDR_SIZE-1:0]             HADDR,
   input  logic [HDATA_SIZE-1:0]             HWDATA,
   output logic [HDATA_SIZE-1:0]             HRDATA,
   input  logic                              HWRITE,
   input  logic [2:0]                        HSIZE,
   input  logic [2:0]                        HBURST,
   input  logic [3:0]                        HPROT,
   input  logic [1:0]                        HTRANS,
   input  logic                              HMASTLOCK,
   input  logic                              HREADY,
   output logic                              HREADYOUT,
   output logic                              HRESP,
   output logic [SLAVES-1:0]                 slvHSEL,
   output logic [HADDR_SIZE-1:0]             slvHADDR,
   output logic [HDATA_SIZE-1:0]             slvHWDATA,
   output logic                              slvHWRITE,
   output logic [2:0]                        slvHSIZE,
   output logic [2:0]                        slvHBURST,
   output logic [3:0]                        slvHPROT,
   output logic [1:0]                        slvHTRANS,
   output logic                              slvHMASTLOCK,
   output logic                              slvHREADY,
   input  logic [SLAVES-1:0][HDATA_SIZE-1:0] slvHRDATA,
   input  logic [SLAVES-1:0]                 slvHREADYOUT,
   input  logic [SLAVES-1:0]                 slvHRESP,
   input  logic [SLAVES-1:0]                 granted,
   output logic [SLAVES-1:0]                 can_switch
);

   localparam int unsigned SW         = (SLAVES > 1) ? $clog2(SLAVES) : 1;
   localparam logic [1:0]  TRANS_BUSY = 2'b01;
   localparam logic [1:0]  TRANS_SEQ  = 2'b11;

   typedef struct packed {
      logic [HADDR_SIZE-1:0] addr;
      logic                  write;
      logic [2:0]            size;
      logic [2:0]            burst;
      logic [3:0]            prot;
      logic [1:0]            trans;
      logic                  lock;
   } req_t;

   typedef enum logic [2:0] {PASS, HOLD, DATA, ERR1, ERR2} state_t;

   state_t            state;
   req_t              hold_req;
   req_t              req_in;
   req_t              req_bus;
   logic [SW-1:0]     s_hold;
   logic [SW-1:0]     s_dp;
   logic [SW-1:0]     hit_idx;
   logic [SLAVES-1:0] hit_onehot;
   logic              hit_any;
   logic              accept;
   logic              dp_ready;
   logic              addr_open;

   // Address decode; the lowest matching slave index wins on overlap.
   always_comb begin
      hit_onehot = '0;
      hit_any    = 1'b0;
      hit_idx    = '0;
      for (int unsigned s = 0; s < SLAVES; s++) begin
         if ((SLAVE_MASK[s] != '0) && (((HADDR ^ SLAVE_ADDR[s]) & SLAVE_MASK[s]) == '0) && !hit_any) begin
            hit_any       = 1'b1;
            hit_idx       = SW'(s);
            hit_onehot[s] = 1'b1;
         end
      end
   end

   always_comb begin
      req_in.addr  = HADDR;
      req_in.write = HWRITE;
      req_in.size  = HSIZE;
      req_in.burst = HBURST;
      req_in.prot  = HPROT;
      req_in.trans = HTRANS;
      req_in.lock  = HMASTLOCK;
   end

   assign req_bus   = (state == HOLD) ? hold_req : req_in;
   assign accept    = HSEL & HREADY & HTRANS[1];
   assign dp_ready  = slvHREADYOUT[s_dp];
   assign addr_open = (state == PASS) || (state == ERR2) || ((state == DATA) && dp_ready);

   // A master address phase can only be taken while the master-side data phase is completing.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state    <= PASS;
         hold_req <= '0;
         s_hold   <= '0;
         s_dp     <= '0;
      end else if (addr_open) begin
         if (accept && hit_any && granted[hit_idx]) begin
            state <= DATA;
            s_dp  <= hit_idx;
         end else if (accept && hit_any) begin
            state    <= HOLD;
            s_hold   <= hit_idx;
            hold_req <= req_in;
         end else if (accept) begin
            state <= ERR1;
         end else begin
            state <= PASS;
         end
      end else if (state == HOLD) begin
         if (granted[s_hold] && slvHREADYOUT[s_hold]) begin
            state <= DATA;
            s_dp  <= s_hold;
         end
      end else if (state == ERR1) begin
         state <= ERR2;
      end
   end

   always_comb begin
      slvHSEL   = HSEL ? hit_onehot : '0;
      slvHREADY = HREADY;
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      HRDATA    = '0;
      case (state)
         HOLD: begin
            slvHSEL   = SLAVES'(1'b1) << s_hold;
            slvHREADY = 1'b1;
            HREADYOUT = 1'b0;
         end
         DATA: begin
            HRDATA    = slvHRDATA[s_dp];
            HREADYOUT = dp_ready;
            HRESP     = slvHRESP[s_dp];
         end
         ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
         end
         ERR2:    HRESP = 1'b1;
         default: ;
      endcase
   end

   assign slvHADDR     = req_bus.addr;
   assign slvHWDATA    = HWDATA;
   assign slvHWRITE    = req_bus.write;
   assign slvHSIZE     = req_bus.size;
   assign slvHBURST    = req_bus.burst;
   assign slvHPROT     = req_bus.prot;
   assign slvHMASTLOCK = req_bus.lock;

   // Keep the slave while a locked sequence, a burst continuation or a held request targets it.
   always_comb begin
      can_switch = '1;
      for (int unsigned s = 0; s < SLAVES; s++) begin
         can_switch[s] = !(slvHSEL[s] && (req_bus.lock || (req_bus.trans == TRANS_SEQ) ||
                           (req_bus.trans == TRANS_BUSY) || ((state == HOLD) && (s_hold == SW'(s)))));
      end
   end

`ifdef AHB3LITE_INTERCONNECT_SEQ2NONSEQ_EN
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   logic [SLAVES-1:0] seen;
   logic [SLAVES-1:0] issue;

   // A slave sees a transfer once its address phase completes under grant; losing grant clears it.
   assign issue = slvHSEL & granted &
                  {SLAVES{slvHREADY & req_bus.trans[1] & ((state != HOLD) | slvHREADYOUT[s_hold])}};

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) seen <= '0;
      else        seen <= (seen | issue) & granted;
   end

   assign slvHTRANS = ((req_bus.trans == TRANS_SEQ) && (slvHSEL != '0) && ((seen & slvHSEL) == '0))
                      ? TRANS_NONSEQ : req_bus.trans;
`else
   assign slvHTRANS = req_bus.trans;
`endif

endmodule

// File: tb/tb_ahb3lite_interconnect_master_port.sv
// Directed bench for ahb3lite_interconnect_master_port with a transaction-level reference model.
module tb_ahb3lite_interconnect_master_port;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned NS = 8;
   localparam logic [NS-1:0][AW-1:0] SA = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_1000, 32'h0000_0000};
   localparam logic [NS-1:0][AW-1:0] SM = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_F000, 32'h0000_F000};

`ifdef AHB3LITE_INTERCONNECT_SEQ2NONSEQ_EN
   localparam logic [1:0] EXP_CROSS = 2'b10;
`else
   localparam logic [1:0] EXP_CROSS = 2'b11;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic hsel, hwrite, hlock, hready, hreadyout, hresp;
   logic [AW-1:0] haddr;
   logic [DW-1:0] hwdata, hrdata;
   logic [2:0] hsize, hburst;
   logic [3:0] hprot;
   logic [1:0] htrans;
   logic [NS-1:0] s_hsel, s_ready, s_resp, granted, can_switch;
   logic [AW-1:0] s_haddr;
   logic [DW-1:0] s_hwdata;
   logic s_hwrite, s_hlock, s_hready;
   logic [2:0] s_hsize, s_hburst;
   logic [3:0] s_hprot;
   logic [1:0] s_htrans;
   logic [NS-1:0][DW-1:0] s_hrdata;

   int checks = 0;
   int failures = 0;

   // single-master system: the master bus HREADY is this port's HREADYOUT
   assign hready = hreadyout;

   always #5 clk = ~clk;

   ahb3lite_interconnect_master_port #(
      .HADDR_SIZE(AW), .HDATA_SIZE(DW), .SLAVES(NS), .SLAVE_ADDR(SA), .SLAVE_MASK(SM)
   ) dut (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(hrdata),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
      .HMASTLOCK(hlock), .HREADY(hready), .HREADYOUT(hreadyout), .HRESP(hresp),
      .slvHSEL(s_hsel), .slvHADDR(s_haddr), .slvHWDATA(s_hwdata), .slvHWRITE(s_hwrite),
      .slvHSIZE(s_hsize), .slvHBURST(s_hburst), .slvHPROT(s_hprot), .slvHTRANS(s_htrans),
      .slvHMASTLOCK(s_hlock), .slvHREADY(s_hready), .slvHRDATA(s_hrdata),
      .slvHREADYOUT(s_ready), .slvHRESP(s_resp), .granted(granted), .can_switch(can_switch)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int wait_on = -1;
   int dp_on = -1;
   int err_left = 0;
   logic [AW-1:0] w_addr = '0;
   logic w_write = 1'b0;
   logic w_lock = 1'b0;
   logic [2:0] w_size = '0, w_burst = '0;
   logic [3:0] w_prot = '0;
   logic [1:0] w_trans = '0;
   logic [NS-1:0] seen = '0;

   logic e_ready, e_resp, e_write, e_lock, e_sready;
   logic [DW-1:0] e_rdata;
   logic [AW-1:0] e_addr;
   logic [2:0] e_size, e_burst;
   logic [3:0] e_prot;
   logic [1:0] e_src_trans, e_trans;
   logic [NS-1:0] e_sel, e_cs;

   function automatic int decode(input logic [AW-1:0] a);
      for (int s = 0; s < NS; s++)
         if (SM[s] != '0 && (a & SM[s]) == (SA[s] & SM[s])) return s;
      return -1;
   endfunction

   task automatic model_reset();
      wait_on = -1; dp_on = -1; err_left = 0; seen = '0;
   endtask

   task automatic model_eval();
      int tgt;
      e_ready = 1'b1; e_resp = 1'b0; e_rdata = '0;
      if (wait_on >= 0) e_ready = 1'b0;
      else if (err_left == 2) begin e_ready = 1'b0; e_resp = 1'b1; end
      else if (err_left == 1) e_resp = 1'b1;
      else if (dp_on >= 0) begin
         e_ready = s_ready[dp_on]; e_resp = s_resp[dp_on]; e_rdata = s_hrdata[dp_on];
      end
      if (wait_on >= 0) begin
         e_addr = w_addr; e_write = w_write; e_size = w_size; e_burst = w_burst;
         e_prot = w_prot; e_src_trans = w_trans; e_lock = w_lock; e_sready = 1'b1;
         tgt = wait_on;
      end else begin
         e_addr = haddr; e_write = hwrite; e_size = hsize; e_burst = hburst;
         e_prot = hprot; e_src_trans = htrans; e_lock = hlock; e_sready = e_ready;
         tgt = hsel ? decode(haddr) : -1;
      end
      e_sel = (tgt >= 0) ? (NS'(1) << tgt) : '0;
      e_trans = e_src_trans;
`ifdef AHB3LITE_INTERCONNECT_SEQ2NONSEQ_EN
      if (tgt >= 0 && e_src_trans == 2'b11 && !seen[tgt]) e_trans = 2'b10;
`endif
      for (int s = 0; s < NS; s++)
         e_cs[s] = !(e_sel[s] && (e_lock || e_src_trans == 2'b11 || e_src_trans == 2'b01 || wait_on == s));
   endtask

   task automatic model_step();
      int t;
      logic [NS-1:0] iss;
      model_eval();
      iss = '0;
      if (wait_on >= 0) begin
         if (granted[wait_on] && s_ready[wait_on]) begin
            iss[wait_on] = 1'b1; dp_on = wait_on; wait_on = -1;
         end
      end else if (e_ready) begin
         dp_on = -1; err_left = 0;
         if (hsel && htrans[1]) begin
            t = decode(haddr);
            if (t < 0) err_left = 2;
            else if (granted[t]) begin dp_on = t; iss[t] = 1'b1; end
            else begin
               wait_on = t; w_addr = haddr; w_write = hwrite; w_size = hsize; w_burst = hburst;
               w_prot = hprot; w_trans = htrans; w_lock = hlock;
            end
         end
      end else if (err_left == 2) err_left = 1;
      seen = (seen | iss) & granted;
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
   end

   // compare every cycle outside reset
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         model_eval();
         chk("m_hreadyout", 64'(hreadyout), 64'(e_ready));
         chk("m_hresp",     64'(hresp),     64'(e_resp));
         chk("m_hrdata",    64'(hrdata),    64'(e_rdata));
         chk("m_slvhsel",   64'(s_hsel),    64'(e_sel));
         chk("m_slvhaddr",  64'(s_haddr),   64'(e_addr));
         chk("m_slvhwrite", 64'(s_hwrite),  64'(e_write));
         chk("m_slvhsize",  64'(s_hsize),   64'(e_size));
         chk("m_slvhburst", 64'(s_hburst),  64'(e_burst));
         chk("m_slvhprot",  64'(s_hprot),   64'(e_prot));
         chk("m_slvhtrans", 64'(s_htrans),  64'(e_trans));
         chk("m_slvhlock",  64'(s_hlock),   64'(e_lock));
         chk("m_slvhready", 64'(s_hready),  64'(e_sready));
         chk("m_slvhwdata", 64'(s_hwdata),  64'(hwdata));
         chk("m_canswitch", 64'(can_switch), 64'(e_cs));
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic sel, input logic [AW-1:0] a, input logic [1:0] tr,
                        input logic wr, input logic [2:0] bu, input logic lk, input logic [DW-1:0] wd);
      hsel = sel; haddr = a; htrans = tr; hwrite = wr; hburst = bu; hlock = lk; hwdata = wd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      hsize = 3'd2; hprot = 4'h3;
      drive(1'b0, 32'h0, 2'b00, 1'b0, 3'd0, 1'b0, 32'h0);
      granted = 8'h03; s_ready = '1; s_resp = '0;
      for (int s = 0; s < NS; s++) s_hrdata[s] = 32'hDA7A_0000 | 32'(s);

      // reset values
      repeat (2) @(posedge clk);
      mid();
      chk("rst_hreadyout", 64'(hreadyout), 64'd1);
      chk("rst_hresp",     64'(hresp),     64'd0);
      chk("rst_hrdata",    64'(hrdata),    64'd0);
      chk("rst_slvhready", 64'(s_hready),  64'd1);
      chk("rst_slvhsel",   64'(s_hsel),    64'd0);
      chk("rst_canswitch", 64'(can_switch), 64'hFF);
      tick();
      rst = 1'b0;

      // granted read to slave 1
      drive(1'b1, 32'h1004, 2'b10, 1'b0, 3'd0, 1'b0, 32'h0);
      mid(); chk("rd_slvhsel", 64'(s_hsel), 64'h02);
      tick();
      drive(1'b0, 32'h0, 2'b00, 1'b0, 3'd0, 1'b0, 32'h0);
      mid(); chk("rd_hrdata", 64'(hrdata), 64'hDA7A0001); chk("rd_hreadyout", 64'(hreadyout), 64'd1);
      tick();

      // write to slave 1 held for three cycles awaiting grant
      granted = 8'h01;
      drive(1'b1, 32'h1008, 2'b10, 1'b1, 3'd0, 1'b0, 32'h0);
      tick();
      drive(1'b1, 32'h1008, 2'b00, 1'b0, 3'd0, 1'b0, 32'hCAFE_0001);
      mid(); chk("hold1_hreadyout", 64'(hreadyout), 64'd0); chk("hold1_addr", 64'(s_haddr), 64'h1008);
      chk("hold1_write", 64'(s_hwrite), 64'd1); chk("hold1_cs1", 64'(can_switch[1]), 64'd0);
      tick();
      mid(); chk("hold2_hreadyout", 64'(hreadyout), 64'd0); chk("hold2_addr", 64'(s_haddr), 64'h1008);
      tick();
      granted = 8'h03;
      mid(); chk("hold3_hreadyout", 64'(hreadyout), 64'd0); chk("hold3_trans", 64'(s_htrans), 64'd2);
      tick();
      mid(); chk("wdp_hreadyout", 64'(hreadyout), 64'd1); chk("wdp_hwdata", 64'(s_hwdata), 64'hCAFE0001);
      tick();
      drive(1'b0, 32'h0, 2'b00, 1'b0, 3'd0, 1'b0, 32'h0);
      tick();

      // unmapped address -> two-cycle ERROR
      drive(1'b1, 32'h9000, 2'b10, 1'b0, 3'd0, 1'b0, 32'h0);
      mid(); chk("err_slvhsel", 64'(s_hsel), 64'd0);
      tick();
      drive(1'b1, 32'h9000, 2'b00, 1'b0, 3'd0, 1'b0, 32'h0);
      mid(); chk("err1_hreadyout", 64'(hreadyout), 64'd0); chk("err1_hresp", 64'(hresp), 64'd1);
      tick();
      mid(); chk("err2_hreadyout", 64'(hreadyout), 64'd1); chk("err2_hresp", 64'(hresp), 64'd1);
      tick();
      mid(); chk("err_done_hresp", 64'(hresp), 64'd0); chk("err_done_slvhsel", 64'(s_hsel), 64'd0);
      tick();

      // INCR4 to slave 1: can_switch held low on SEQ beats
      for (int b = 0; b < 4; b++) begin
         drive(1'b1, 32'h1000 + 32'(4 * b), (b == 0) ? 2'b10 : 2'b11, 1'b0, 3'b011, 1'b0, 32'h0);
         mid(); chk("incr4_cs1", 64'(can_switch[1]), (b == 0) ? 64'd1 : 64'd0);
         chk("incr4_cs0", 64'(can_switch[0]), 64'd1);
         tick();
      end
      drive(1'b1, 32'h100C, 2'b00, 1'b0, 3'b011, 1'b0, 32'h0);
      mid(); chk("incr4_idle_cs1", 64'(can_switch[1]), 64'd1);
      tick();

      // back-to-back: slave 0 granted, slave 1 not
      granted = 8'h01;
      drive(1'b1, 32'h0010, 2'b10, 1'b0, 3'd0, 1'b0, 32'h0);
      mid(); chk("b2b_a_hreadyout", 64'(hreadyout), 64'd1);
      tick();
      drive(1'b1, 32'h1010, 2'b10, 1'b0, 3'd0, 1'b0, 32'h0);
      mid(); chk("b2b_s0_hrdata", 64'(hrdata), 64'hDA7A0000); chk("b2b_b_hreadyout", 64'(hreadyout), 64'd1);
      tick();
      drive(1'b0, 32'h0, 2'b00, 1'b0, 3'd0, 1'b0, 32'h0);
      mid(); chk("b2b_hold_hreadyout", 64'(hreadyout), 64'd0); chk("b2b_hold_addr", 64'(s_haddr), 64'h1010);
      tick();
      granted = 8'h03;
      tick();
      mid(); chk("b2b_s1_hrdata", 64'(hrdata), 64'hDA7A0001);
      tick();

      // burst crossing slave 0 -> slave 1 after slave 1 grant was lost and regained
      granted = 8'h01; tick();
      granted = 8'h03; tick();
      drive(1'b1, 32'h0FF8, 2'b10, 1'b0, 3'b001, 1'b0, 32'h0); tick();
      drive(1'b1, 32'h0FFC, 2'b11, 1'b0, 3'b001, 1'b0, 32'h0); tick();
      drive(1'b1, 32'h1000, 2'b11, 1'b0, 3'b001, 1'b0, 32'h0);
      mid(); chk("cross_first_trans", 64'(s_htrans), 64'(EXP_CROSS)); chk("cross_slvhsel", 64'(s_hsel), 64'h02);
      tick();
      drive(1'b1, 32'h1004, 2'b11, 1'b0, 3'b001, 1'b0, 32'h0);
      mid(); chk("cross_next_trans", 64'(s_htrans), 64'd3);
      tick();
      drive(1'b0, 32'h0, 2'b00, 1'b0, 3'd0, 1'b0, 32'h0); tick();

      // slave ERROR with wait state passed through
      drive(1'b1, 32'h0020, 2'b10, 1'b0, 3'd0, 1'b0, 32'h0); tick();
      drive(1'b1, 32'h0020, 2'b00, 1'b0, 3'd0, 1'b0, 32'h0);
      s_ready[0] = 1'b0; s_resp[0] = 1'b1;
      mid(); chk("serr1_hreadyout", 64'(hreadyout), 64'd0); chk("serr1_hresp", 64'(hresp), 64'd1);
      tick();
      s_ready[0] = 1'b1;
      mid(); chk("serr2_hreadyout", 64'(hreadyout), 64'd1); chk("serr2_hresp", 64'(hresp), 64'd1);
      tick();
      s_resp[0] = 1'b0;
      mid(); chk("serr_done_hresp", 64'(hresp), 64'd0);
      tick();

      // locked transfer pins can_switch
      drive(1'b1, 32'h0030, 2'b10, 1'b0, 3'd0, 1'b1, 32'h0);
      mid(); chk("lock_canswitch", 64'(can_switch), 64'hFE);
      tick();
      drive(1'b0, 32'h0, 2'b00, 1'b0, 3'd0, 1'b0, 32'h0); tick(); tick();

      // reset mid-HOLD drops the pending transfer
      granted = 8'h01;
      drive(1'b1, 32'h1040, 2'b10, 1'b0, 3'd0, 1'b0, 32'h0); tick();
      drive(1'b0, 32'h0, 2'b00, 1'b0, 3'd0, 1'b0, 32'h0);
      mid(); chk("rhold_hreadyout", 64'(hreadyout), 64'd0);
      tick();
      rst = 1'b1;
      #1;
      chk("rhold_rst_hreadyout", 64'(hreadyout), 64'd1);
      chk("rhold_rst_slvhsel", 64'(s_hsel), 64'd0);
      chk("rhold_rst_canswitch", 64'(can_switch), 64'hFF);
      tick();
      rst = 1'b0; granted = 8'h03;
      mid(); chk("post_rst_hreadyout", 64'(hreadyout), 64'd1); chk("post_rst_hresp", 64'(hresp), 64'd0);
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
